// File: rtl/smps_pkg.sv
// Shared definitions for the SMPS control path: sequencer state encoding and
// the default duty/compensator word widths used by dpwm, soft_start and compensator.
package smps_pkg;

    localparam int SMPS_DUTY_W = 11;
    localparam int SMPS_COMP_W = 10;

    typedef enum logic [2:0] {
        SEQ_IDLE       = 3'd0,
        SEQ_SOFT_START = 3'd1,
        SEQ_HANDOFF    = 3'd2,
        SEQ_REGULATE   = 3'd3,
        SEQ_RAMP_DOWN  = 3'd4,
        SEQ_FAULT      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/duty_slew.sv
// Slew engine for the on-time word: tick divider, target register and the
// saturating step toward the target. Sequencing decisions live in duty_sequencer.
module duty_slew
    import smps_pkg::*;
#(
    parameter int DUTY_W    = SMPS_DUTY_W,
    parameter int COMP_W    = SMPS_COMP_W,
    parameter int D_MAX     = 800,
    parameter int D_MIN     = 16,
    parameter int SLEW_STEP = 4,
    parameter int SLEW_DIV  = 8
) (
    input  logic              i_clk,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              force_zero,
    input  logic              load_en,
    input  logic [DUTY_W-1:0] load_duty,
    input  logic              tgt_load,
    input  logic [COMP_W-1:0] tgt_duty,
    input  logic              tgt_zero,
    input  logic              step_en,
    output logic [DUTY_W-1:0] ton,
    output logic              reach_zero
);

    localparam int CNT_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SLEW_DIV - 1);
    localparam logic [DUTY_W-1:0] MAX_C    = DUTY_W'(D_MAX);
    localparam logic [DUTY_W-1:0] MIN_C    = DUTY_W'(D_MIN);
    localparam logic [DUTY_W-1:0] STEP_C   = DUTY_W'(SLEW_STEP);

    logic [CNT_W-1:0]  cnt;
    logic [DUTY_W-1:0] target;
    logic              wrap;
    logic              tick;

    // Upper saturation only (soft-start path)
    function automatic logic [DUTY_W-1:0] sat_max(input logic [DUTY_W-1:0] d);
        return (d > MAX_C) ? MAX_C : d;
    endfunction

    // Compensator word zero-extended and clamped into the regulation window
    function automatic logic [DUTY_W-1:0] clamp_comp(input logic [COMP_W-1:0] d);
        logic [DUTY_W-1:0] ext;
        ext = DUTY_W'(d);
        if (ext > MAX_C) return MAX_C;
        if (ext < MIN_C) return MIN_C;
        return ext;
    endfunction

    // Move toward the target by at most one step; never passes the target,
    // so the result stays inside [0, D_MAX] when the target does
    function automatic logic [DUTY_W-1:0] slew_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        if (tgt > cur) return ((tgt - cur) > STEP_C) ? (cur + STEP_C) : tgt;
        return ((cur - tgt) > STEP_C) ? (cur - STEP_C) : tgt;
    endfunction

    assign wrap       = (cnt == CNT_LAST);
    assign tick       = wrap & ~restart & step_en;
    // True when a downward step this cycle lands on zero (or it is already zero)
    assign reach_zero = (ton == '0) || (wrap && (ton <= STEP_C));

    // Tick divider: wraps every SLEW_DIV cycles, realigned on every state entry
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n)              cnt <= '0;
        else if (restart || wrap)  cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end

    // Target register; a load coinciding with a tick only affects later ticks
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n)                    target <= '0;
        else if (force_zero || tgt_zero) target <= '0;
        else if (tgt_load)               target <= clamp_comp(tgt_duty);
    end

    // On-time word: forced off, directly loaded during soft-start, else slewed
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n)        ton <= '0;
        else if (force_zero) ton <= '0;
        else if (load_en)    ton <= sat_max(load_duty);
        else if (tick)       ton <= slew_toward(ton, target);
    end

endmodule

// File: rtl/duty_sequencer.sv
// Duty-cycle arbiter and power sequencer in front of dpwm: chooses between the
// soft-start ramp, the compensator and a controlled ramp-down, and forces the
// converter off on a fault.
module duty_sequencer
    import smps_pkg::*;
#(
    parameter int DUTY_W    = SMPS_DUTY_W,
    parameter int COMP_W    = SMPS_COMP_W,
    parameter int D_MAX     = 800,
    parameter int D_MIN     = 16,
    parameter int SLEW_STEP = 4,
    parameter int SLEW_DIV  = 8
) (
    input  logic              i_clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_shutdown,
    input  logic              i_fault,
    input  logic [DUTY_W-1:0] i_ss_duty,
    input  logic              i_ss_done,
    input  logic [COMP_W-1:0] i_comp_duty,
    input  logic              i_comp_valid,
    output logic [DUTY_W-1:0] o_ton,
    output logic              o_dpwm_en,
    output logic              o_ss_en,
    output logic              o_done,
    output logic [2:0]        o_state
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       stop_req;
    logic       reach_zero;
    logic       restart;
    logic       force_zero;
    logic       load_en;
    logic       tgt_load;
    logic       tgt_zero;
    logic       step_en;

    assign stop_req = i_shutdown | ~i_start;

    // Next state: fault first, then shutdown/start-drop, then normal progress
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE: begin
                if (i_start && !i_fault && !i_shutdown) state_d = SEQ_SOFT_START;
            end
            SEQ_SOFT_START: begin
                if (i_fault)        state_d = SEQ_FAULT;
                else if (stop_req)  state_d = SEQ_RAMP_DOWN;
                else if (i_ss_done) state_d = SEQ_HANDOFF;
            end
            SEQ_HANDOFF: begin
                if (i_fault)           state_d = SEQ_FAULT;
                else if (stop_req)     state_d = SEQ_RAMP_DOWN;
                else if (i_comp_valid) state_d = SEQ_REGULATE;
            end
            SEQ_REGULATE: begin
                if (i_fault)       state_d = SEQ_FAULT;
                else if (stop_req) state_d = SEQ_RAMP_DOWN;
            end
            SEQ_RAMP_DOWN: begin
                if (i_fault)         state_d = SEQ_FAULT;
                else if (reach_zero) state_d = SEQ_IDLE;
            end
            SEQ_FAULT: begin
                if (!i_fault && !i_start) state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Slew engine controls are derived from the state being entered so that
    // o_ton and the registered flags change on the same edge
    assign restart    = (state_d != state_q);
    assign force_zero = (state_d == SEQ_IDLE) || (state_d == SEQ_FAULT);
    assign load_en    = (state_d == SEQ_SOFT_START);
    assign tgt_load   = i_comp_valid && (state_d == SEQ_REGULATE);
    assign tgt_zero   = (state_d == SEQ_RAMP_DOWN);
    assign step_en    = (state_q == SEQ_REGULATE) || (state_q == SEQ_RAMP_DOWN);

    duty_slew #(
        .DUTY_W   (DUTY_W),
        .COMP_W   (COMP_W),
        .D_MAX    (D_MAX),
        .D_MIN    (D_MIN),
        .SLEW_STEP(SLEW_STEP),
        .SLEW_DIV (SLEW_DIV)
    ) u_slew (
        .i_clk     (i_clk),
        .reset_n   (reset_n),
        .restart   (restart),
        .force_zero(force_zero),
        .load_en   (load_en),
        .load_duty (i_ss_duty),
        .tgt_load  (tgt_load),
        .tgt_duty  (i_comp_duty),
        .tgt_zero  (tgt_zero),
        .step_en   (step_en),
        .ton       (o_ton),
        .reach_zero(reach_zero)
    );

    // State register and registered control outputs
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEQ_IDLE;
            o_dpwm_en <= 1'b0;
            o_ss_en   <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_dpwm_en <= (state_d == SEQ_SOFT_START) || (state_d == SEQ_HANDOFF) ||
                         (state_d == SEQ_REGULATE)   || (state_d == SEQ_RAMP_DOWN);
            o_ss_en   <= (state_d == SEQ_SOFT_START);
            o_done    <= (state_q == SEQ_RAMP_DOWN) && (state_d == SEQ_IDLE);
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_duty_sequencer.sv
// Directed bench for duty_sequencer with SLEW_STEP=4, SLEW_DIV=8, D_MAX=800, D_MIN=16.
module tb_duty_sequencer;

    logic        i_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_shutdown = 1'b0;
    logic        i_fault = 1'b0;
    logic [10:0] i_ss_duty = '0;
    logic        i_ss_done = 1'b0;
    logic [9:0]  i_comp_duty = '0;
    logic        i_comp_valid = 1'b0;
    logic [10:0] o_ton;
    logic        o_dpwm_en;
    logic        o_ss_en;
    logic        o_done;
    logic [2:0]  o_state;

    int n_cmp = 0;
    int n_bad = 0;

    duty_sequencer #(
        .DUTY_W(11), .COMP_W(10), .D_MAX(800), .D_MIN(16), .SLEW_STEP(4), .SLEW_DIV(8)
    ) dut (
        .i_clk       (i_clk),
        .reset_n     (reset_n),
        .i_start     (i_start),
        .i_shutdown  (i_shutdown),
        .i_fault     (i_fault),
        .i_ss_duty   (i_ss_duty),
        .i_ss_done   (i_ss_done),
        .i_comp_duty (i_comp_duty),
        .i_comp_valid(i_comp_valid),
        .o_ton       (o_ton),
        .o_dpwm_en   (o_dpwm_en),
        .o_ss_en     (o_ss_en),
        .o_done      (o_done),
        .o_state     (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_cmp++;
        if ({o_ton, o_dpwm_en, o_ss_en, o_done, o_state} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_outputs ton=%0d en=%b ss=%b done=%b st=%0d exp all 0",
                     o_ton, o_dpwm_en, o_ss_en, o_done, o_state);
        end
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        n_cmp++;
        if (o_state !== 3'd0 || o_ton !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_release st=%0d ton=%0d exp st=0 ton=0", o_state, o_ton);
        end
    endtask

    task automatic test_startup();
        int duties [5] = '{100, 200, 300, 900, 400};
        int expect_ton [5] = '{100, 200, 300, 800, 400};
        i_start = 1'b1;
        i_ss_duty = 11'd0;
        cyc(1);
        n_cmp++;
        if (o_state !== 3'd1 || o_ss_en !== 1'b1 || o_dpwm_en !== 1'b1 || o_ton !== 11'd0) begin
            n_bad++;
            $display("FAIL startup_enter st=%0d ss=%b en=%b ton=%0d exp st=1 ss=1 en=1 ton=0",
                     o_state, o_ss_en, o_dpwm_en, o_ton);
        end
        for (int k = 0; k < 5; k++) begin
            i_ss_duty = 11'(duties[k]);
            cyc(1);
            n_cmp++;
            if (o_ton !== 11'(expect_ton[k]) || o_ss_en !== 1'b1) begin
                n_bad++;
                $display("FAIL startup_track ss_duty=%0d ton=%0d ss=%b exp ton=%0d ss=1",
                         duties[k], o_ton, o_ss_en, expect_ton[k]);
            end
        end
        i_ss_done = 1'b1;
        cyc(1);
        i_ss_done = 1'b0;
        n_cmp++;
        if (o_state !== 3'd2 || o_ss_en !== 1'b0 || o_dpwm_en !== 1'b1 || o_ton !== 11'd400) begin
            n_bad++;
            $display("FAIL handoff_enter st=%0d ss=%b en=%b ton=%0d exp st=2 ss=0 en=1 ton=400",
                     o_state, o_ss_en, o_dpwm_en, o_ton);
        end
        i_ss_duty = 11'd0;
        cyc(3);
        n_cmp++;
        if (o_state !== 3'd2 || o_ton !== 11'd400) begin
            n_bad++;
            $display("FAIL handoff_hold st=%0d ton=%0d exp st=2 ton=400", o_state, o_ton);
        end
    endtask

    task automatic test_regulation_slew();
        int exp_ton;
        i_comp_valid = 1'b1;
        i_comp_duty = 10'd400;
        cyc(1);
        i_comp_valid = 1'b0;
        n_cmp++;
        if (o_state !== 3'd3 || o_ton !== 11'd400) begin
            n_bad++;
            $display("FAIL regulate_enter st=%0d ton=%0d exp st=3 ton=400", o_state, o_ton);
        end
        for (int n = 1; n <= 48; n++) begin
            i_comp_valid = (n == 1);
            i_comp_duty = 10'd420;
            cyc(1);
            exp_ton = 400 + 4 * (((n / 8) > 5) ? 5 : (n / 8));
            n_cmp++;
            if (o_ton !== 11'(exp_ton)) begin
                n_bad++;
                $display("FAIL regulate_slew cycle=%0d ton=%0d exp=%0d", n, o_ton, exp_ton);
            end
        end
        i_comp_valid = 1'b0;
    endtask

    task automatic test_saturation();
        int lo;
        int hi;
        lo = 2047;
        hi = 0;
        for (int n = 0; n < 800; n++) begin
            i_comp_valid = (n == 0);
            i_comp_duty = 10'd1023;
            cyc(1);
            if (int'(o_ton) < lo) lo = int'(o_ton);
            if (int'(o_ton) > hi) hi = int'(o_ton);
        end
        n_cmp++;
        if (o_ton !== 11'd800) begin
            n_bad++;
            $display("FAIL sat_high ton=%0d exp=800", o_ton);
        end
        for (int n = 0; n < 1600; n++) begin
            i_comp_valid = (n == 0);
            i_comp_duty = 10'd5;
            cyc(1);
            if (int'(o_ton) < lo) lo = int'(o_ton);
            if (int'(o_ton) > hi) hi = int'(o_ton);
        end
        n_cmp++;
        if (o_ton !== 11'd16) begin
            n_bad++;
            $display("FAIL sat_low ton=%0d exp=16", o_ton);
        end
        n_cmp++;
        if (lo < 16 || hi > 800) begin
            n_bad++;
            $display("FAIL sat_range min=%0d max=%0d exp within 16..800", lo, hi);
        end
        for (int n = 0; n < 16; n++) begin
            i_comp_valid = (n == 0);
            i_comp_duty = 10'd20;
            cyc(1);
        end
        i_comp_valid = 1'b0;
        n_cmp++;
        if (o_ton !== 11'd20) begin
            n_bad++;
            $display("FAIL sat_to_20 ton=%0d exp=20", o_ton);
        end
    endtask

    task automatic test_shutdown();
        int exp_ton;
        i_shutdown = 1'b1;
        cyc(1);
        n_cmp++;
        if (o_state !== 3'd4 || o_ton !== 11'd20 || o_dpwm_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rampdown_enter st=%0d ton=%0d en=%b exp st=4 ton=20 en=1",
                     o_state, o_ton, o_dpwm_en);
        end
        for (int n = 1; n <= 40; n++) begin
            cyc(1);
            exp_ton = 20 - 4 * (n / 8);
            n_cmp++;
            if (o_ton !== 11'(exp_ton)) begin
                n_bad++;
                $display("FAIL rampdown_ton cycle=%0d ton=%0d exp=%0d", n, o_ton, exp_ton);
            end
            n_cmp++;
            if (n < 40) begin
                if (o_done !== 1'b0 || o_dpwm_en !== 1'b1 || o_state !== 3'd4) begin
                    n_bad++;
                    $display("FAIL rampdown_flags cycle=%0d done=%b en=%b st=%0d exp done=0 en=1 st=4",
                             n, o_done, o_dpwm_en, o_state);
                end
            end else begin
                if (o_done !== 1'b1 || o_dpwm_en !== 1'b0 || o_state !== 3'd0) begin
                    n_bad++;
                    $display("FAIL rampdown_finish done=%b en=%b st=%0d exp done=1 en=0 st=0",
                             o_done, o_dpwm_en, o_state);
                end
            end
        end
        cyc(1);
        n_cmp++;
        if (o_done !== 1'b0 || o_state !== 3'd0) begin
            n_bad++;
            $display("FAIL done_pulse done=%b st=%0d exp done=0 st=0", o_done, o_state);
        end
        i_shutdown = 1'b0;
        i_start = 1'b0;
        cyc(1);
    endtask

    task automatic test_fault();
        i_start = 1'b1;
        i_ss_duty = 11'd400;
        cyc(1);
        i_ss_done = 1'b1;
        cyc(1);
        i_ss_done = 1'b0;
        i_comp_valid = 1'b1;
        i_comp_duty = 10'd420;
        cyc(1);
        i_comp_valid = 1'b0;
        cyc(40);
        n_cmp++;
        if (o_state !== 3'd3 || o_ton !== 11'd420) begin
            n_bad++;
            $display("FAIL fault_setup st=%0d ton=%0d exp st=3 ton=420", o_state, o_ton);
        end
        i_fault = 1'b1;
        cyc(1);
        n_cmp++;
        if (o_ton !== 11'd0 || o_dpwm_en !== 1'b0 || o_ss_en !== 1'b0 || o_state !== 3'd5) begin
            n_bad++;
            $display("FAIL fault_off ton=%0d en=%b ss=%b st=%0d exp ton=0 en=0 ss=0 st=5",
                     o_ton, o_dpwm_en, o_ss_en, o_state);
        end
        i_fault = 1'b0;
        cyc(2);
        n_cmp++;
        if (o_state !== 3'd5 || o_dpwm_en !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_latched st=%0d en=%b exp st=5 en=0", o_state, o_dpwm_en);
        end
        i_start = 1'b0;
        cyc(1);
        n_cmp++;
        if (o_state !== 3'd0 || o_done !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_rearm st=%0d done=%b exp st=0 done=0", o_state, o_done);
        end
        i_fault = 1'b1;
        i_start = 1'b1;
        i_ss_duty = 11'd200;
        cyc(2);
        n_cmp++;
        if (o_state !== 3'd0 || o_dpwm_en !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_idle_block st=%0d en=%b exp st=0 en=0", o_state, o_dpwm_en);
        end
        i_fault = 1'b0;
        cyc(1);
        n_cmp++;
        if (o_state !== 3'd1 || o_ton !== 11'd200) begin
            n_bad++;
            $display("FAIL fault_clear_start st=%0d ton=%0d exp st=1 ton=200", o_state, o_ton);
        end
    endtask

    task automatic test_back_to_back_reset();
        i_shutdown = 1'b1;
        i_ss_done = 1'b1;
        cyc(1);
        i_ss_done = 1'b0;
        n_cmp++;
        if (o_state !== 3'd4 || o_ton !== 11'd200) begin
            n_bad++;
            $display("FAIL shutdown_wins st=%0d ton=%0d exp st=4 ton=200", o_state, o_ton);
        end
        cyc(3);
        n_cmp++;
        if (o_state !== 3'd4 || o_ton !== 11'd200 || o_dpwm_en !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_before_reset st=%0d ton=%0d en=%b exp st=4 ton=200 en=1",
                     o_state, o_ton, o_dpwm_en);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_ton, o_dpwm_en, o_ss_en, o_done, o_state} !== 17'd0) begin
            n_bad++;
            $display("FAIL async_reset ton=%0d en=%b ss=%b done=%b st=%0d exp all 0",
                     o_ton, o_dpwm_en, o_ss_en, o_done, o_state);
        end
        #1;
        i_shutdown = 1'b0;
        i_start = 1'b0;
        reset_n = 1'b1;
        cyc(1);
        n_cmp++;
        if (o_state !== 3'd0 || o_ton !== 11'd0 || o_dpwm_en !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset st=%0d ton=%0d en=%b exp st=0 ton=0 en=0",
                     o_state, o_ton, o_dpwm_en);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_regulation_slew();
        test_saturation();
        test_shutdown();
        test_fault();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout sim_time=%0t limit=1000000", $time);
        $fatal(1, "bench did not finish in time");
    end

endmodule
